// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation datapath.
package rsa_pkg;

    // Default operand/modulus/result width.
    localparam int RSA_WIDTH = 8;

    // Modexp sequencer states. IDLE is the reset state and is left only via
    // a restart/load strobe. SQR and MUL alternate per exponent bit.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PREP = 3'd2,
        SQR  = 3'd3,
        MUL  = 3'd4,
        DONE = 3'd5
    } modexp_state_e;

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod m in exactly W
// enabled cycles, MSB of a first. The first step runs in the start cycle
// itself, and p/done are combinational on the final step, so the caller
// can latch the product on the same edge that retires the last bit.
// Precondition: b < m, which keeps the accumulator below m after each step.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int W = RSA_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] p
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    // 2*acc + b < 3m < 2^(W+2), so two spare bits cover the intermediate sum.
    logic [W+1:0]  acc_q, acc_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic [W+1:0]  acc_in, m_ext, b_ext, t0, t1, t2;
    logic          bit_sel;

    // One interleaved step: shift-add the selected bit, then reduce at most twice.
    always_comb begin
        m_ext   = {2'b00, m};
        b_ext   = {2'b00, b};
        acc_in  = start ? '0 : acc_q;
        bit_sel = start ? a[W-1] : a[cnt_q];
        t0      = (acc_in << 1) + (bit_sel ? b_ext : '0);
        t1      = (t0 >= m_ext) ? (t0 - m_ext) : t0;
        t2      = (t1 >= m_ext) ? (t1 - m_ext) : t1;
    end

    // Step sequencing: start loads bit W-1, then count down to bit 0.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            acc_d  = t2;
            cnt_d  = IW'(W - 2);
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = t2;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - IW'(1);
            end
        end
    end

    // Multiplier registers; everything freezes while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (en) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == '0) && !start;
    assign p    = t2[W-1:0];

endmodule

// File: rtl/rsa_modexp_unit.sv
// Left-to-right square-and-multiply modular exponentiation:
// result = plain^exponent mod modulus. Driven by the enable/control FSM
// (en, active-low rst_rsa restart strobe); eoc flags a finished result.
// Latency from the launching LOAD edge is WIDTH*(1+WIDTH+popcount(exponent))
// enabled cycles: every modmul is WIDTH cycles and the LOAD edge is the
// first PREP step, so no cycles are spent between operations.
module rsa_modexp_unit
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rst_rsa,
    input  logic [WIDTH-1:0] plain,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result,
    output logic             eoc
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    modexp_state_e    state_q, state_d;
    logic [WIDTH-1:0] plain_q, plain_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             eoc_q, eoc_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic             mm_start, mm_busy, mm_done;
    logic [WIDTH-1:0] mm_a, mm_b, mm_p;

    // Operand mux for the single shared multiplier: (plain,1) reduces the
    // base, (R,R) squares, (R,B) multiplies.
    always_comb begin
        mm_a = plain_q;
        mm_b = WIDTH'(1);
        case (state_q)
            SQR: begin
                mm_a = r_q;
                mm_b = r_q;
            end
            MUL: begin
                mm_a = r_q;
                mm_b = b_q;
            end
            default: ;
        endcase
    end

    rsa_modmul #(.W(WIDTH)) u_modmul (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .m     (mod_q),
        .busy  (mm_busy),
        .done  (mm_done),
        .p     (mm_p)
    );

    // Next-state logic; a low rst_rsa overrides every state and recaptures inputs.
    always_comb begin
        state_d  = state_q;
        plain_d  = plain_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        r_d      = r_q;
        b_d      = b_q;
        result_d = result_q;
        eoc_d    = eoc_q;
        idx_d    = idx_q;
        mm_start = 1'b0;
        if (!rst_rsa) begin
            state_d = LOAD;
            eoc_d   = 1'b0;
            plain_d = plain;
            exp_d   = exponent;
            mod_d   = modulus;
        end else begin
            case (state_q)
                IDLE: ;
                LOAD: begin
                    if (mod_q < WIDTH'(2)) begin
                        state_d  = DONE;
                        result_d = '0;
                        eoc_d    = 1'b1;
                    end else begin
                        state_d  = PREP;
                        r_d      = WIDTH'(1);
                        idx_d    = IW'(WIDTH - 1);
                        mm_start = 1'b1;
                    end
                end
                PREP: begin
                    if (mm_done) begin
                        b_d     = mm_p;
                        state_d = SQR;
                    end
                end
                SQR: begin
                    mm_start = !mm_busy;
                    if (mm_done) begin
                        r_d = mm_p;
                        if (exp_q[idx_q]) begin
                            state_d = MUL;
                        end else if (idx_q == '0) begin
                            state_d  = DONE;
                            result_d = mm_p;
                            eoc_d    = 1'b1;
                        end else begin
                            idx_d = idx_q - IW'(1);
                        end
                    end
                end
                MUL: begin
                    mm_start = !mm_busy;
                    if (mm_done) begin
                        r_d = mm_p;
                        if (idx_q == '0) begin
                            state_d  = DONE;
                            result_d = mm_p;
                            eoc_d    = 1'b1;
                        end else begin
                            state_d = SQR;
                            idx_d   = idx_q - IW'(1);
                        end
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers; en low freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            plain_q  <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            r_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            eoc_q    <= 1'b0;
            idx_q    <= '0;
        end else if (en) begin
            state_q  <= state_d;
            plain_q  <= plain_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            r_q      <= r_d;
            b_q      <= b_d;
            result_q <= result_d;
            eoc_q    <= eoc_d;
            idx_q    <= idx_d;
        end
    end

    assign result = result_q;
    assign eoc    = eoc_q;

endmodule

// File: doc/rsa_modexp_unit.md
Name: rsa_modexp_unit

Overview:
Iterative modular-exponentiation engine computing RESULT = PLAIN^EXP mod MOD, for encryption and decryption alike.
- Sits directly downstream of the enable/control FSM and consumes its outputs: en_rsa drives en, rst_rsa drives rst_rsa.
- Returns eoc to that FSM as eoc_rsa_unit.
- Algorithm: left-to-right square-and-multiply built on a bit-serial interleaved modular multiplier.

Parameters:
WIDTH, 8, operand/modulus/result bit width (≥2).

Ports:
clk  input  1  system clock, all flops on rising edge
rst  input  1  asynchronous active-high reset
en  input  1  clock enable; when 0 every register holds
rst_rsa  input  1  synchronous active-low restart/load strobe, sampled only when en=1
plain  input  WIDTH  base operand
exponent  input  WIDTH  exponent
modulus  input  WIDTH  modulus
result  output  WIDTH  registered result, valid while eoc=1
eoc  output  1  registered end-of-conversion

Behaviour:
- Reset (rst=1, async): state=IDLE; result=0; eoc=0; all internal registers=0.
- en=0: full freeze. No state, counter, operand or output change, and rst_rsa is ignored.
- When en=1, rst_rsa=0 has priority over everything:
  - next state=LOAD, eoc←0, result unchanged.
  - plain/exponent/modulus are captured every cycle while in LOAD.
- Inputs are ignored outside LOAD; mid-run input changes have no effect.
- States:
  - IDLE: left only via rst_rsa=0 → LOAD. rst_rsa=1 stays IDLE.
  - LOAD: on rst_rsa=1 → if captured modulus<2 → DONE with result←0; else PREP with R←1, bit index i←WIDTH-1.
  - PREP: computes B=modmul(plain,1), which reduces plain mod M so any plain ≥ M is legal. Then → SQR.
  - SQR: R←modmul(R,R). Then if exponent[i]=1 → MUL; else if i=0 → DONE; else i←i-1, SQR.
  - MUL: R←modmul(R,B). Then if i=0 → DONE; else i←i-1, SQR.
  - DONE: result←R and eoc←1 on the entry edge. Holds until rst_rsa=0 (→LOAD, eoc←0 next edge).
- modmul(A,Bop), interleaved, exactly WIDTH enabled cycles, MSB of A first:
  - acc←2·acc+(A[j]?Bop:0); then subtract M while acc≥M, at most twice.
  - acc is WIDTH+2 bits wide. Precondition Bop<M, guaranteed by PREP and by R<M.
  - acc clears at each modmul start.
- Latency: eoc is high after exactly N=WIDTH·(1+WIDTH+popcount(exponent)) enabled cycles, counted from the first en=1 cycle with rst_rsa=1 in LOAD.
  - No leading-zero skipping: the latency is data-dependent only via popcount.
  - modulus<2: eoc after 1 enabled cycle.
- exponent=0 with M≥2 → result=1. plain=0 → result=0 unless exponent=0.
- rst_rsa=0 mid-PREP/SQR/MUL aborts the run with no partial result. result keeps its previous DONE value; eoc stays 0.
- rst asserted at any time → immediate IDLE; outputs go to 0 asynchronously.

Decomposition:
- Package rsa_pkg:
  - typedef enum for modexp states {IDLE, LOAD, PREP, SQR, MUL, DONE}.
  - RSA_WIDTH default constant (8).
  - shared with the control FSM's state typedef.
- Sub-module rsa_modmul: bit-serial interleaved multiplier.
  - ports: clk, rst, en, start, a, b, m, busy, done, p.
  - instantiated once; the top muxes operands per state (PREP: plain,1; SQR: R,R; MUL: R,B).

Test Plan:
1. WIDTH=8, rst pulse, then en=1; rst_rsa=0 two cycles with plain=9, exponent=7, modulus=143; then rst_rsa=1 → eoc rises after exactly 96 cycles, result=48.
2. Decrypt: plain=48, exponent=103, modulus=143 → result=9 after 112 cycles; eoc and result stay stable until rst_rsa=0, then eoc=0 next edge.
3. Boundaries:
   - plain=200, exponent=1, modulus=13 → result=5 after 80 cycles.
   - exponent=0, modulus=13 → result=1 after 72 cycles.
   - modulus=1 or 0 → result=0, eoc after 1 cycle.
4. en gating: in case 1, toggle en low for 20 random cycles mid-run → result=48 and eoc exactly 96 enabled cycles after start. Inputs changed mid-run are ignored.
5. Abort: rst_rsa=0 at cycle 40 of a run, then new operands plain=5, exponent=3, modulus=13 → eoc=0 during the run, result=8 after 88 cycles.
6. Async reset asserted mid-run (between clock edges) → result=0, eoc=0 immediately. With rst_rsa=1 held after release the unit stays IDLE, and eoc never rises.
